reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Owns system reset after async power-on. Holds every downstream domain in reset, waits for the
//  clock source to report lock, then releases NUM_STAGES resets in fixed order (clock-enable gen,
//  memory/IO, 6502 core) with programmed gaps. Re-sequences on soft reset or lock loss.
//  Sits between the board reset input and the synchronous reset pins of the system blocks.
// PARAMETERS
//  NUM_STAGES   3     number of ordered reset outputs; stage 0 released first (1..8)
//  HOLD_CYCLES  16    enabled clocks all stages stay asserted before lock check (>=1)
//  STAGE_GAP    8     enabled clocks between successive stage releases (>=1)
//  LOCK_TIMEOUT 1024  enabled clocks allowed in WAIT_LOCK before timeout (>=2)
//  WDOG_CYCLES  65536 watchdog period in enabled clocks (WATCHDOG_EN builds only)
// PORTS
//  clk            in   1           system clock
//  async_reset_n  in   1           asynchronous active-low reset, whole block
//  clk_enable     in   1           qualifies every counter increment
//  lock_i         in   1           clock-source lock, asynchronous; 2-flop synced internally
//  soft_rst_req   in   1           1-clk pulse: request warm reset
//  wdog_kick      in   1           1-clk pulse: restart watchdog (ignored w/o WATCHDOG_EN)
//  stage_rst      out  NUM_STAGES  active-high sync resets, bit k = stage k
//  seq_done       out  1           1 while in RUN
//  lock_timeout   out  1           sticky; set on WAIT_LOCK timeout, cleared only by async reset
//  rst_cause      out  2           cause of last sequence: 00 POR, 01 soft, 10 lock loss, 11 wdog
// BEHAVIOUR
//  Reset (async_reset_n=0): stage_rst=all 1, seq_done=0, lock_timeout=0, rst_cause=00,
//   state=HOLD, counters=0, sync flops=0. All outputs registered.
//  HOLD: count HOLD_CYCLES enabled clocks, then -> WAIT_LOCK. stage_rst all 1.
//  WAIT_LOCK: lock_sync=1 -> RELEASE, stage index k=0, stage_rst[0] cleared on that edge.
//   Counter reaches LOCK_TIMEOUT w/o lock -> set lock_timeout, -> HOLD (retry forever).
//  RELEASE: after STAGE_GAP enabled clocks clear stage_rst[k+1]; after last stage's gap -> RUN.
//   Released bits stay 0; no bit is cleared out of order.
//  RUN: seq_done=1. Exits only on a restart event.
//  Restart events (any state except HOLD): on the next edge stage_rst=all 1, seq_done=0,
//   counters=0, state=HOLD, rst_cause updated. Ignored while already in HOLD (counter not reset).
//   lock loss = lock_sync falling while in RELEASE or RUN.
//  Simultaneous events: priority lock loss > watchdog > soft; rst_cause records the winner.
//  clk_enable=0: counters frozen; restart events and WAIT_LOCK->RELEASE on lock still act.
//  Counter widths: $clog2(max(HOLD_CYCLES,STAGE_GAP,LOCK_TIMEOUT)+1); no wrap reachable.
//  Latency with lock stable and clk_enable=1: stage_rst[0] falls on edge HOLD_CYCLES+1 after
//   async_reset_n rises; stage k on edge HOLD_CYCLES+1+k*STAGE_GAP; seq_done rises
//   STAGE_GAP edges after the last stage.
// CONFIGURATION
//  RESET_SEQ_WATCHDOG_EN defined: watchdog counter runs in RUN only, cleared by wdog_kick
//   or leaving RUN; reaching WDOG_CYCLES = restart event with rst_cause=11.
//  Not defined: no watchdog logic; wdog_kick unused; rst_cause never 11.
// TESTING (NUM_STAGES=3, HOLD_CYCLES=4, STAGE_GAP=2, LOCK_TIMEOUT=8, WDOG_CYCLES=16)
//  POR, lock_i=1, clk_enable=1 -> stage_rst 111->110 @edge5, 100 @7, 000 @9, seq_done=1 @11.
//  lock_i=0 held -> lock_timeout=1 after HOLD+8 clocks, stage_rst stays 111, HOLD re-entered.
//  soft_rst_req in RUN -> next edge stage_rst=111, rst_cause=01, full sequence repeats.
//  lock_i drop in RELEASE with soft_rst_req same cycle -> rst_cause=10, stage_rst=111.
//  clk_enable 1-of-3 duty -> every interval stretched 3x, order unchanged.
//  WATCHDOG_EN, no kicks in RUN -> restart after 16 clocks, rst_cause=11; kicks every 10 -> no restart.

Source files
------------

// File: rtl/reset_sequencer.sv
// Ordered reset release: hold, wait for lock, then drop stage resets in turn.
// Optional watchdog restart when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer #(
    parameter int NUM_STAGES   = 3,
    parameter int HOLD_CYCLES  = 16,
    parameter int STAGE_GAP    = 8,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int WDOG_CYCLES  = 65536
) (
    input  logic                  clk,
    input  logic                  async_reset_n,
    input  logic                  clk_enable,
    input  logic                  lock_i,
    input  logic                  soft_rst_req,
    input  logic                  wdog_kick,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  seq_done,
    output logic                  lock_timeout,
    output logic [1:0]            rst_cause
);

    typedef enum logic [1:0] {
        S_HOLD,
        S_WAIT_LOCK,
        S_RELEASE,
        S_RUN
    } state_t;

    localparam logic [1:0] CAUSE_SOFT = 2'b01;
    localparam logic [1:0] CAUSE_LOCK = 2'b10;
    localparam logic [1:0] CAUSE_WDOG = 2'b11;

    localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ?
                             HOLD_CYCLES : STAGE_GAP;
    localparam int MAX_CNT = (MAX_HG > LOCK_TIMEOUT) ?
                             MAX_HG : LOCK_TIMEOUT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [CW-1:0] LT_LAST   = CW'(LOCK_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]   stage_d;
    logic                    done_d;
    logic                    lt_d;
    logic [1:0]              cause_d;
    logic                    sync1_q, lock_sync;
    logic                    lock_loss;
    logic                    wdog_fire;
    logic                    restart;

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            sync1_q   <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            sync1_q   <= lock_i;
            lock_sync <= sync1_q;
        end
    end

    // Lock can only be lost after it was seen high on entry to RELEASE.
    assign lock_loss = !lock_sync &&
                       (state_q == S_RELEASE || state_q == S_RUN);

    assign restart = (state_q != S_HOLD) &&
                     (lock_loss || wdog_fire || soft_rst_req);

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d    = '0;
        wdog_fire = 1'b0;
        if (state_q == S_RUN && !wdog_kick) begin
            wdog_d = wdog_q;
            if (clk_enable) begin
                if (wdog_q == WDOG_LAST) begin
                    wdog_fire = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
        end
        if (restart) begin
            wdog_d = '0;
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    localparam int unused_wdog_cycles = WDOG_CYCLES;
    logic unused_kick;
    assign unused_kick = wdog_kick;
    assign wdog_fire   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_rst;
        done_d  = seq_done;
        lt_d    = lock_timeout;
        cause_d = rst_cause;
        if (restart) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            stage_d = '1;
            done_d  = 1'b0;
            if (lock_loss) begin
                cause_d = CAUSE_LOCK;
            end else if (wdog_fire) begin
                cause_d = CAUSE_WDOG;
            end else begin
                cause_d = CAUSE_SOFT;
            end
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (clk_enable) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = S_WAIT_LOCK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_sync) begin
                        state_d = S_RELEASE;
                        cnt_d   = '0;
                        stage_d = stage_rst << 1;
                    end else if (clk_enable) begin
                        if (cnt_q == LT_LAST) begin
                            state_d = S_HOLD;
                            cnt_d   = '0;
                            lt_d    = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    // Released bits form a low-order run of zeros,
                    // so shifting left clears exactly the next stage.
                    if (clk_enable) begin
                        if (cnt_q == GAP_LAST) begin
                            cnt_d = '0;
                            if (stage_rst == '0) begin
                                state_d = S_RUN;
                                done_d  = 1'b1;
                            end else begin
                                stage_d = stage_rst << 1;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    done_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            stage_rst    <= '1;
            seq_done     <= 1'b0;
            lock_timeout <= 1'b0;
            rst_cause    <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_rst    <= stage_d;
            seq_done     <= done_d;
            lock_timeout <= lt_d;
            rst_cause    <= cause_d;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed and randomized bench for reset_sequencer against a
// phase/elapsed-time model of the release schedule.
module tb_reset_sequencer;

    localparam int N    = 3;
    localparam int HOLD = 4;
    localparam int GAP  = 2;
    localparam int LT   = 8;
    localparam int WDOG = 16;

    localparam int P_HOLD = 0;
    localparam int P_WAIT = 1;
    localparam int P_REL  = 2;
    localparam int P_RUN  = 3;

    logic         clk = 1'b0;
    logic         async_reset_n;
    logic         clk_enable;
    logic         lock_i;
    logic         soft_rst_req;
    logic         wdog_kick;
    logic [N-1:0] stage_rst;
    logic         seq_done;
    logic         lock_timeout;
    logic [1:0]   rst_cause;

    int checks = 0;
    int errors = 0;

    int         ph;
    int         el;
    int         wd;
    bit         s1, s2;
    bit         m_lt;
    logic [1:0] m_cause;

    reset_sequencer #(
        .NUM_STAGES  (N),
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .LOCK_TIMEOUT(LT),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .clk_enable   (clk_enable),
        .lock_i       (lock_i),
        .soft_rst_req (soft_rst_req),
        .wdog_kick    (wdog_kick),
        .stage_rst    (stage_rst),
        .seq_done     (seq_done),
        .lock_timeout (lock_timeout),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph      = P_HOLD;
        el      = 0;
        wd      = 0;
        s1      = 1'b0;
        s2      = 1'b0;
        m_lt    = 1'b0;
        m_cause = 2'b00;
    endtask

    // Stage k is released k*GAP enabled clocks after RELEASE is entered.
    function automatic logic [N-1:0] exp_stage();
        logic [N-1:0] ones;
        int rel;
        ones = '1;
        if (ph == P_HOLD || ph == P_WAIT) return ones;
        if (ph == P_RUN) return '0;
        rel = 1 + el / GAP;
        if (rel > N) rel = N;
        return ones << rel;
    endfunction

    task automatic model_edge();
        bit sync_now, loss, fire, rs;
        sync_now = s2;
        s2 = s1;
        s1 = lock_i;
        loss = !sync_now && (ph == P_REL || ph == P_RUN);
        fire = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        fire = (ph == P_RUN) && clk_enable && !wdog_kick &&
               (wd + 1 == WDOG);
`endif
        rs = (ph != P_HOLD) && (loss || fire || soft_rst_req);
        if (rs) begin
            ph = P_HOLD;
            el = 0;
            wd = 0;
            m_cause = loss ? 2'b10 : (fire ? 2'b11 : 2'b01);
        end else if (ph == P_HOLD) begin
            if (clk_enable) el++;
            if (el == HOLD) begin
                ph = P_WAIT;
                el = 0;
            end
        end else if (ph == P_WAIT) begin
            if (sync_now) begin
                ph = P_REL;
                el = 0;
            end else if (clk_enable) begin
                el++;
                if (el == LT) begin
                    m_lt = 1'b1;
                    ph = P_HOLD;
                    el = 0;
                end
            end
        end else if (ph == P_REL) begin
            if (clk_enable) el++;
            if (el == N * GAP) begin
                ph = P_RUN;
                el = 0;
                wd = 0;
            end
        end else begin
            if (wdog_kick) wd = 0;
            else if (clk_enable) wd++;
        end
    endtask

    task automatic check_model();
        chk("stage_rst", 8'(stage_rst), 8'(exp_stage()));
        chk("seq_done", 8'(seq_done), 8'(ph == P_RUN));
        chk("lock_timeout", 8'(lock_timeout), 8'(m_lt));
        chk("rst_cause", 8'(rst_cause), 8'(m_cause));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (seq_done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 8'(seq_done), 8'd1);
    endtask

    initial begin
        int t100, t000, tdone;
        logic [N-1:0] prev;
        async_reset_n = 1'b0;
        clk_enable    = 1'b0;
        lock_i        = 1'b0;
        soft_rst_req  = 1'b0;
        wdog_kick     = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_stage", 8'(stage_rst), 8'h07);
        chk("rst_done", 8'(seq_done), 8'd0);
        chk("rst_lt", 8'(lock_timeout), 8'd0);
        chk("rst_cause", 8'(rst_cause), 8'd0);

        // Power-on sequence with lock already present
        async_reset_n = 1'b1;
        lock_i        = 1'b1;
        clk_enable    = 1'b1;
        repeat (4) step();
        chk("por_e4", 8'(stage_rst), 8'h07);
        step();
        chk("por_e5", 8'(stage_rst), 8'h06);
        step();
        step();
        chk("por_e7", 8'(stage_rst), 8'h04);
        step();
        step();
        chk("por_e9", 8'(stage_rst), 8'h00);
        step();
        chk("por_e10", 8'(seq_done), 8'd0);
        step();
        chk("por_e11", 8'(seq_done), 8'd1);
        repeat (3) step();

        // Soft reset from RUN
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        chk("soft_stage", 8'(stage_rst), 8'h07);
        chk("soft_cause", 8'(rst_cause), 8'h01);
        wait_done("soft_redo", 40);

        // Lock loss in RELEASE coinciding with a soft request
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        begin
            int n;
            n = 0;
            while (stage_rst !== 3'b110 && n < 20) begin
                step();
                n++;
            end
        end
        chk("ll_release", 8'(stage_rst), 8'h06);
        lock_i = 1'b0;
        step();
        step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        chk("ll_cause", 8'(rst_cause), 8'h02);
        chk("ll_stage", 8'(stage_rst), 8'h07);

        // No lock: timeout after HOLD + LT clocks, then retry
        repeat (HOLD + LT - 1) step();
        chk("lt_before", 8'(lock_timeout), 8'd0);
        step();
        chk("lt_set", 8'(lock_timeout), 8'd1);
        chk("lt_stage", 8'(stage_rst), 8'h07);
        repeat (5) step();

        // Lock restored under 1-of-3 clock enable
        lock_i = 1'b1;
        t100 = -1;
        t000 = -1;
        tdone = -1;
        for (int i = 0; i < 90; i++) begin
            clk_enable = (i % 3 == 0);
            prev = stage_rst;
            step();
            if (prev == 3'b110 && stage_rst == 3'b100) t100 = i;
            if (prev == 3'b100 && stage_rst == 3'b000) t000 = i;
            if (seq_done && tdone < 0) tdone = i;
        end
        chk("duty_gap1", 8'(t000 - t100), 8'(3 * GAP));
        chk("duty_gap2", 8'(tdone - t000), 8'(3 * GAP));
        chk("duty_done", 8'(seq_done), 8'd1);

        // Random traffic
        clk_enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 24) == 0) lock_i = ~lock_i;
            clk_enable   = ($urandom_range(0, 3) != 0);
            soft_rst_req = ($urandom_range(0, 39) == 0);
            wdog_kick    = ($urandom_range(0, 7) == 0);
            step();
        end
        soft_rst_req = 1'b0;
        wdog_kick    = 1'b0;
        clk_enable   = 1'b1;
        lock_i       = 1'b1;
        repeat (3) step();
        soft_rst_req = 1'b1;
        step();
        soft_rst_req = 1'b0;
        wait_done("rand_recover", 60);

`ifdef RESET_SEQ_WATCHDOG_EN
        repeat (WDOG - 1) step();
        chk("wd_hold", 8'(seq_done), 8'd1);
        step();
        chk("wd_fire", 8'(rst_cause), 8'h03);
        chk("wd_stage", 8'(stage_rst), 8'h07);
        wait_done("wd_redo", 40);
        for (int i = 1; i <= 60; i++) begin
            wdog_kick = (i % 10 == 0);
            step();
        end
        wdog_kick = 1'b0;
        chk("wd_kicked", 8'(seq_done), 8'd1);
`endif

        // Asynchronous reset mid-run clears the sticky flag
        async_reset_n = 1'b0;
        model_reset();
        #1;
        chk("ar_stage", 8'(stage_rst), 8'h07);
        chk("ar_done", 8'(seq_done), 8'd0);
        chk("ar_lt", 8'(lock_timeout), 8'd0);
        chk("ar_cause", 8'(rst_cause), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
